ext_clock_monitor: RTL and testbench



---
 rtl/ext_clock_monitor_pkg.sv | 22 ++
 rtl/ext_clock_monitor_edge_sync_detect.sv | 23 ++
 rtl/ext_clock_monitor.sv | 160 ++++++++++++++++
 tb/tb_ext_clock_monitor.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_clock_monitor_pkg.sv
// Shared encodings and default constants for the external reference clock monitor.
package ext_clock_monitor_pkg;

  typedef enum logic [1:0] {
    ST_INT    = 2'd0,
    ST_TO_EXT = 2'd1,
    ST_EXT    = 2'd2,
    ST_TO_INT = 2'd3
  } mon_state_e;

  localparam int unsigned REF_FREQ_HZ     = 10_000_000;
  localparam int unsigned SYS_FREQ_HZ     = 250_000_000;
  localparam int unsigned DEF_GATE_CYCLES = 25_000;
  localparam int unsigned DEF_EXP_COUNT   = DEF_GATE_CYCLES / (SYS_FREQ_HZ / REF_FREQ_HZ);
  localparam int unsigned SYNC_STAGES     = 3;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ext_clock_monitor_edge_sync_detect.sv
// Multi-flop synchronizer for an asynchronous level with a single-cycle rising-edge strobe.
module ext_clock_monitor_edge_sync_detect
  import ext_clock_monitor_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise_c
);

  logic [SYNC_STAGES-1:0] sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], async_in};
    end
  end

  assign rise_c = sync[SYNC_STAGES-2] & ~sync[SYNC_STAGES-1];

endmodule

// File: rtl/ext_clock_monitor.sv
// Gated edge-count frequency monitor for the external reference; qualifies it with
// hysteresis and switches the PLL reference mux behind a PLL reset pulse.
module ext_clock_monitor
  import ext_clock_monitor_pkg::*;
#(
  parameter int unsigned GATE_CYCLES    = DEF_GATE_CYCLES,
  parameter int unsigned EXP_COUNT      = DEF_EXP_COUNT,
  parameter int unsigned TOL            = 2,
  parameter int unsigned GOOD_WINDOWS   = 8,
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned COUNT_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ext_clk_in,
  input  logic                   allow_ext,
  output logic [COUNT_WIDTH-1:0] meas_count,
  output logic                   meas_valid,
  output logic                   ext_present,
  output logic                   pll_clk_sel,
  output logic                   pll_rst,
  output logic                   ext_clock_selected
);

  localparam int unsigned TIMER_W  = cnt_bits(GATE_CYCLES);
  localparam int unsigned STREAK_W = cnt_bits(GOOD_WINDOWS + 1);
  localparam int unsigned XFER_W   = cnt_bits(PLL_RST_CYCLES);
  localparam int unsigned CMP_W    = COUNT_WIDTH + 1;

  localparam logic [CMP_W-1:0]    LO_BOUND     = (EXP_COUNT > TOL) ? CMP_W'(EXP_COUNT - TOL) : '0;
  localparam logic [CMP_W-1:0]    HI_BOUND     = CMP_W'(EXP_COUNT + TOL);
  localparam logic [TIMER_W-1:0]  TIMER_RELOAD = TIMER_W'(GATE_CYCLES - 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX   = STREAK_W'(GOOD_WINDOWS);
  localparam logic [XFER_W-1:0]   XFER_LAST    = XFER_W'(PLL_RST_CYCLES - 1);

  logic                   rise_c;
  logic [COUNT_WIDTH-1:0] edge_cnt;
  logic [COUNT_WIDTH-1:0] close_cnt_c;
  logic [TIMER_W-1:0]     gate_timer;
  logic [STREAK_W-1:0]    good_streak;
  logic                   win_close_c;
  logic                   win_good_c;

  mon_state_e          state, state_d;
  logic [XFER_W-1:0]   xfer_cnt, xfer_cnt_d;
  logic                pending_bad, pending_bad_d;
  logic                pll_rst_d, pll_clk_sel_d, ext_sel_d;
  logic                bad_close_c;
  logic                streak_full_c;

  ext_clock_monitor_edge_sync_detect u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (ext_clk_in),
    .rise_c   (rise_c)
  );

  // Count value including an edge landing this cycle, saturating at all-ones.
  assign close_cnt_c = (rise_c && (edge_cnt != '1)) ? edge_cnt + COUNT_WIDTH'(1) : edge_cnt;
  assign win_close_c = (gate_timer == '0);
  assign win_good_c  = ({1'b0, close_cnt_c} >= LO_BOUND) && ({1'b0, close_cnt_c} <= HI_BOUND);

  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt    <= '0;
      gate_timer  <= TIMER_RELOAD;
      meas_count  <= '0;
      meas_valid  <= 1'b0;
      ext_present <= 1'b0;
      good_streak <= '0;
    end else begin
      meas_valid <= win_close_c;
      if (win_close_c) begin
        edge_cnt    <= '0;
        gate_timer  <= TIMER_RELOAD;
        meas_count  <= close_cnt_c;
        ext_present <= win_good_c;
        if (!win_good_c) begin
          good_streak <= '0;
        end else if (good_streak != STREAK_MAX) begin
          good_streak <= good_streak + STREAK_W'(1);
        end
      end else begin
        edge_cnt   <= close_cnt_c;
        gate_timer <= gate_timer - TIMER_W'(1);
      end
    end
  end

  assign bad_close_c   = meas_valid & ~ext_present;
  assign streak_full_c = (good_streak == STREAK_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= ST_INT;
      xfer_cnt           <= '0;
      pending_bad        <= 1'b0;
      pll_rst            <= 1'b0;
      pll_clk_sel        <= 1'b0;
      ext_clock_selected <= 1'b0;
    end else begin
      state              <= state_d;
      xfer_cnt           <= xfer_cnt_d;
      pending_bad        <= pending_bad_d;
      pll_rst            <= pll_rst_d;
      pll_clk_sel        <= pll_clk_sel_d;
      ext_clock_selected <= ext_sel_d;
    end
  end

  // Next state; outputs are decoded from the next state so they register in step with it.
  always_comb begin
    state_d       = state;
    xfer_cnt_d    = '0;
    pending_bad_d = pending_bad;
    pll_rst_d     = 1'b0;
    pll_clk_sel_d = 1'b0;
    ext_sel_d     = 1'b0;

    case (state)
      ST_INT: begin
        if (streak_full_c && allow_ext) begin
          state_d       = ST_TO_EXT;
          pending_bad_d = 1'b0;
        end
      end
      ST_TO_EXT: begin
        if (bad_close_c) pending_bad_d = 1'b1;
        if (xfer_cnt == XFER_LAST) state_d = ST_EXT;
        else xfer_cnt_d = xfer_cnt + XFER_W'(1);
      end
      ST_EXT: begin
        if (bad_close_c || !allow_ext || pending_bad) state_d = ST_TO_INT;
      end
      ST_TO_INT: begin
        if (xfer_cnt == XFER_LAST) state_d = ST_INT;
        else xfer_cnt_d = xfer_cnt + XFER_W'(1);
      end
      default: state_d = ST_INT;
    endcase

    // The mux select moves one cycle into the reset pulse.
    case (state_d)
      ST_TO_EXT: begin
        pll_rst_d     = 1'b1;
        pll_clk_sel_d = (xfer_cnt_d != '0);
      end
      ST_EXT: begin
        pll_clk_sel_d = 1'b1;
        ext_sel_d     = 1'b1;
      end
      ST_TO_INT: begin
        pll_rst_d     = 1'b1;
        pll_clk_sel_d = (xfer_cnt_d == '0);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ext_clock_monitor.sv
// Self-checking bench: phase-accumulator ext clock source, window scoreboard, scenario table
// and hand-written transition sequences.
module tb_ext_clock_monitor;

  localparam int unsigned GATE  = 200;
  localparam int unsigned EXPC  = 10;
  localparam int unsigned TOLC  = 2;
  localparam int unsigned GOODW = 8;
  localparam int unsigned PRST  = 16;
  localparam int unsigned CW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          ext_clk_in;
  logic          allow_ext;
  logic [CW-1:0] meas_count;
  logic          meas_valid;
  logic          ext_present;
  logic          pll_clk_sel;
  logic          pll_rst;
  logic          ext_clock_selected;

  always #2 clk = ~clk;

  ext_clock_monitor #(
    .GATE_CYCLES    (GATE),
    .EXP_COUNT      (EXPC),
    .TOL            (TOLC),
    .GOOD_WINDOWS   (GOODW),
    .PLL_RST_CYCLES (PRST),
    .COUNT_WIDTH    (CW)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .ext_clk_in         (ext_clk_in),
    .allow_ext          (allow_ext),
    .meas_count         (meas_count),
    .meas_valid         (meas_valid),
    .ext_present        (ext_present),
    .pll_clk_sel        (pll_clk_sel),
    .pll_rst            (pll_rst),
    .ext_clock_selected (ext_clock_selected)
  );

  typedef struct {
    int  count;
    bit  present;
  } meas_t;

  typedef struct {
    int unsigned k;
    bit          allow;
    int          windows;
    bit          sel;
    bit          selected;
  } row_t;

  int          n_checks = 0;
  int          n_fails  = 0;
  int          pcount   = 0;
  int          p0       = 0;
  int          prev_close = 0;
  bit          released = 1'b0;
  bit          close_now;
  int unsigned acc      = 0;
  int unsigned k_rate   = 0;
  int          rise_q[$];
  meas_t       sb_q[$];
  row_t        tbl[5];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock: sample at negedge, score windows, then drive the next ext level.
  task automatic step();
    int    cnt;
    bit    nv;
    meas_t m;
    @(negedge clk);
    pcount++;
    if (rst) begin
      released = 1'b0;
    end else if (!released) begin
      released   = 1'b1;
      p0         = pcount;
      prev_close = pcount - 1;
    end
    close_now = released && (((pcount - p0) % GATE) == GATE - 1);
    if (close_now) begin
      cnt = 0;
      while (rise_q.size() > 0 && rise_q[0] <= pcount) begin
        if (rise_q[0] > prev_close) cnt++;
        void'(rise_q.pop_front());
      end
      prev_close = pcount;
      m.count    = cnt;
      m.present  = (cnt >= int'(EXPC - TOLC)) && (cnt <= int'(EXPC + TOLC));
      sb_q.push_back(m);
    end
    chk("meas_valid", int'(meas_valid), int'(close_now));
    if (meas_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL meas_valid: got 1 with no window expected at t=%0t", $time);
      end else begin
        m = sb_q.pop_front();
        chk("meas_count", int'(meas_count), m.count);
        chk("ext_present", int'(ext_present), int'(m.present));
      end
    end
    if (rst) begin
      acc        = 0;
      ext_clk_in = 1'b0;
    end else begin
      acc = (acc + k_rate) % GATE;
      nv  = (acc >= GATE / 2);
      if (nv && !ext_clk_in) rise_q.push_back(pcount + 3);
      ext_clk_in = nv;
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_windows(input int n);
    int seen   = 0;
    int budget = (n + 1) * int'(GATE) + 10;
    while (seen < n && budget > 0) begin
      step();
      if (meas_valid) seen++;
      budget--;
    end
    if (seen < n) begin
      n_checks++;
      n_fails++;
      $display("FAIL wait_windows: got %0d windows, expected %0d", seen, n);
    end
  endtask

  // Checks the 16-cycle reset pulse with the select flipping on its 2nd cycle.
  task automatic pulse_check(input bit to_ext);
    for (int i = 1; i <= int'(PRST); i++) begin
      step();
      chk("pulse_pll_rst", int'(pll_rst), 1);
      chk("pulse_pll_clk_sel", int'(pll_clk_sel), to_ext ? int'(i >= 2) : int'(i < 2));
      chk("pulse_ext_selected", int'(ext_clock_selected), 0);
    end
    step();
    chk("post_pll_rst", int'(pll_rst), 0);
    chk("post_pll_clk_sel", int'(pll_clk_sel), int'(to_ext));
    chk("post_ext_selected", int'(ext_clock_selected), int'(to_ext));
  endtask

  initial begin
    int n;
    rst        = 1'b1;
    allow_ext  = 1'b0;
    ext_clk_in = 1'b0;
    k_rate     = 13;
    steps(5);
    chk("rst_meas_count", int'(meas_count), 0);
    chk("rst_meas_valid", int'(meas_valid), 0);
    chk("rst_ext_present", int'(ext_present), 0);
    chk("rst_pll_clk_sel", int'(pll_clk_sel), 0);
    chk("rst_pll_rst", int'(pll_rst), 0);
    chk("rst_ext_selected", int'(ext_clock_selected), 0);
    rst = 1'b0;

    // rate (edges/window), allow, windows, expected sel, expected selected
    tbl[0] = '{13, 1'b1, 10, 1'b0, 1'b0};
    tbl[1] = '{12, 1'b1, 10, 1'b1, 1'b1};
    tbl[2] = '{0,  1'b1, 2,  1'b0, 1'b0};
    tbl[3] = '{10, 1'b0, 10, 1'b0, 1'b0};
    tbl[4] = '{10, 1'b1, 1,  1'b1, 1'b1};
    for (int r = 0; r < 5; r++) begin
      k_rate    = tbl[r].k;
      allow_ext = tbl[r].allow;
      wait_windows(tbl[r].windows);
      steps(20);
      chk($sformatf("row%0d_pll_clk_sel", r), int'(pll_clk_sel), int'(tbl[r].sel));
      chk($sformatf("row%0d_ext_selected", r), int'(ext_clock_selected), int'(tbl[r].selected));
      chk($sformatf("row%0d_pll_rst", r), int'(pll_rst), 0);
    end

    // Drop allow in EXT, then reselect without a fresh qualification run.
    allow_ext = 1'b0;
    pulse_check(1'b0);
    allow_ext = 1'b1;
    pulse_check(1'b1);

    // Reset in the 5th cycle of TO_EXT.
    allow_ext = 1'b0;
    steps(20);
    allow_ext = 1'b1;
    steps(5);
    chk("mid_xfer_pll_rst", int'(pll_rst), 1);
    rst = 1'b1;
    step();
    chk("midrst_meas_count", int'(meas_count), 0);
    chk("midrst_meas_valid", int'(meas_valid), 0);
    chk("midrst_ext_present", int'(ext_present), 0);
    chk("midrst_pll_clk_sel", int'(pll_clk_sel), 0);
    chk("midrst_pll_rst", int'(pll_rst), 0);
    chk("midrst_ext_selected", int'(ext_clock_selected), 0);
    steps(4);
    rst = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (!meas_valid && n < int'(GATE) + 5);
    chk("first_window_cycles", n, int'(GATE));

    // One bad window among good ones delays selection by a full streak.
    wait_windows(2);
    k_rate = 20;
    wait_windows(1);
    k_rate = 10;
    wait_windows(GOODW - 1);
    steps(20);
    chk("glitch_early_ext_selected", int'(ext_clock_selected), 0);
    chk("glitch_early_pll_clk_sel", int'(pll_clk_sel), 0);
    wait_windows(1);
    steps(20);
    chk("glitch_late_ext_selected", int'(ext_clock_selected), 1);
    chk("glitch_late_pll_clk_sel", int'(pll_clk_sel), 1);

    // Bad window closing inside TO_EXT forces an exit on the first EXT cycle.
    allow_ext = 1'b0;
    steps(20);
    wait_windows(1);
    k_rate = 20;
    steps(GATE - 10);
    allow_ext = 1'b1;
    pulse_check(1'b1);
    step();
    chk("pending_pll_rst", int'(pll_rst), 1);
    chk("pending_ext_selected", int'(ext_clock_selected), 0);
    chk("pending_pll_clk_sel", int'(pll_clk_sel), 1);
    steps(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
